// File: rtl/mem_bridge_pkg.sv
// Shared constants for mem_bridge: bus width and FSM state encodings.
package mem_bridge_pkg;

    localparam int RegBus = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_bridge_wdog.sv
// Bus-cycle watchdog for mem_bridge; only built when MEM_BRIDGE_TIMEOUT_EN is defined.
// Flags the last BUSY cycle of an access that has gone TIMEOUT cycles without ack.
module mem_bridge_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Counts elapsed BUSY cycles; cleared as soon as the bridge leaves BUSY.
    always_comb begin
        cnt_d = '0;
        if (busy_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the final cycle still wins over the abort.
    assign expire_o = busy_i && !ack_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Core data-memory port to single-master bus bridge, one access in flight.
// Optional bus timeout abort enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [RegBus-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [RegBus-1:0] cpu_data_i,
    output logic [RegBus-1:0] cpu_data_o,
    output logic              stall_req_o,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [RegBus-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [RegBus-1:0] bus_data_o,
    input  logic [RegBus-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              err_o
);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [RegBus-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [RegBus-1:0] wdata_q, wdata_d;
    logic [RegBus-1:0] rdata_q, rdata_d;
    logic              busy;
    logic              expire;

    assign busy = (state_q == ST_BUSY);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic err_q;

    mem_bridge_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy_i   (busy),
        .ack_i    (bus_ack_i),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
        end
    end

    assign err_o = err_q;
`else
    assign expire = 1'b0;
    assign err_o  = 1'b0;
`endif

    // Handshake: the core holds cpu_ce_i until it sees stall_req_o low; that
    // happens only in DONE, and a new request is taken only from IDLE.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_ce_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = {cpu_addr_i[RegBus-1:2], 2'b00};
                    sel_d   = cpu_sel_i;
                    wdata_d = cpu_data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus_ack_i) begin
                    if (!we_q) begin
                        rdata_d = bus_data_i;
                    end
                    state_d = ST_DONE;
                end else if (expire) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_req_o = cpu_ce_i && (state_q != ST_DONE);
    assign bus_cyc_o   = busy;
    assign bus_stb_o   = busy;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_data_o  = wdata_q;
    assign cpu_data_o  = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_bridge;

    localparam int TIMEOUT = 16;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stall_req_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .stall_req_o (stall_req_o),
        .bus_cyc_o   (bus_cyc_o),
        .bus_stb_o   (bus_stb_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_data_o  (bus_data_o),
        .bus_data_i  (bus_data_i),
        .bus_ack_i   (bus_ack_i),
        .err_o       (err_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending access, its latched fields, last read result.
    int          m_phase = 0;   // 0 no access, 1 access on bus, 2 release cycle
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [3:0]  m_sel   = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            m_phase = 0; m_cnt = 0; m_we = 1'b0; m_addr = '0; m_sel = '0;
            m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_valid = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_phase == 0) begin
                if (cpu_ce_i) begin
                    m_we    = cpu_we_i;
                    m_addr  = cpu_addr_i & 32'hFFFF_FFFC;
                    m_sel   = cpu_sel_i;
                    m_wdata = cpu_data_i;
                    m_cnt   = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus_ack_i) begin
                    if (!m_we) m_rdata = bus_data_i;
                    m_phase = 2;
                end else begin
                    m_cnt++;
                    if (TO_EN && m_cnt == TIMEOUT) begin
                        m_rdata = '0;
                        m_err   = 1'b1;
                        m_phase = 2;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("m_stall", {31'd0, stall_req_o}, {31'd0, cpu_ce_i && (m_phase != 2)});
            chk("m_cyc",   {31'd0, bus_cyc_o},   {31'd0, m_phase == 1});
            chk("m_stb",   {31'd0, bus_stb_o},   {31'd0, m_phase == 1});
            chk("m_we",    {31'd0, bus_we_o},    {31'd0, m_we});
            chk("m_addr",  bus_addr_o,           m_addr);
            chk("m_sel",   {28'd0, bus_sel_o},   {28'd0, m_sel});
            chk("m_wdata", bus_data_o,           m_wdata);
            chk("m_rdata", cpu_data_o,           m_rdata);
            chk("m_err",   {31'd0, err_o},       {31'd0, m_err});
        end
    end

    // Driver: one access with `waits` ack-less BUSY cycles; cpu inputs are
    // scrambled in the second BUSY cycle to show the latched copy holds.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, output int stalls);
        logic [31:0] exp_cpu;
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
        #1;
        stalls = int'(stall_req_o);
        chk("req_cyc", {31'd0, bus_cyc_o}, 32'd0);
        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            stalls += int'(stall_req_o);
            chk("busy_cyc",  {31'd0, bus_cyc_o}, 32'd1);
            chk("busy_addr", bus_addr_o, exp_addr);
            chk("busy_sel",  {28'd0, bus_sel_o}, {28'd0, sel});
            chk("busy_we",   {31'd0, bus_we_o}, {31'd0, we});
            if (we) chk("busy_wdata", bus_data_o, wdata);
            if (w == 1) begin
                cpu_we_i = ~we; cpu_addr_i = ~addr; cpu_sel_i = ~sel; cpu_data_i = ~wdata;
            end
            if (w == waits) begin
                bus_ack_i = 1'b1; bus_data_i = rdata;
            end
        end
        @(negedge clk);
        stalls += int'(stall_req_o);
        chk("done_stall", {31'd0, stall_req_o}, 32'd0);
        chk("done_cyc",   {31'd0, bus_cyc_o}, 32'd0);
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd0, 32'd1);
        end else begin
            exp_cpu = exp_q.pop_front();
            chk("done_rdata", cpu_data_o, exp_cpu);
        end
        bus_ack_i = 1'b0; bus_data_i = 32'h5A5A_5A5A; cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("idle_cyc", {31'd0, bus_cyc_o}, 32'd0);
    endtask

    initial begin
        int st;
        rst_n = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        cpu_data_i = '0; bus_data_i = '0; bus_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", cpu_data_o, 32'd0);
        chk("rst_addr",  bus_addr_o, 32'd0);
        chk("rst_wdata", bus_data_o, 32'd0);
        chk("rst_sel",   {28'd0, bus_sel_o}, 32'd0);
        chk("rst_ctl",   {28'd0, bus_cyc_o, bus_stb_o, bus_we_o, err_o}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);

        // Minimum-latency read.
        exp_q.push_back(32'hDEAD_BEEF);
        xact(1'b0, 32'h0000_0104, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 32'h0000_0104, st);
        chk("rd_stall_cycles", 32'(st), 32'd2);

        // Write with 3 wait cycles, unaligned address; read data unchanged.
        exp_q.push_back(32'hDEAD_BEEF);
        xact(1'b1, 32'h0000_0013, 4'b0010, 32'h0000_AB00, 3, 32'h7777_7777, 32'h0000_0010, st);
        chk("wr_stall_cycles", 32'(st), 32'd5);

        // Top-of-map read, 2 waits.
        exp_q.push_back(32'hA5A5_0F0F);
        xact(1'b0, 32'hFFFF_FFFF, 4'b1000, 32'h0, 2, 32'hA5A5_0F0F, 32'hFFFF_FFFC, st);
        chk("rd2_stall_cycles", 32'(st), 32'd4);

        // Stray ack while idle is ignored.
        @(negedge clk);
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        @(negedge clk);
        bus_ack_i = 1'b0;
        chk("idle_ack_rdata", cpu_data_o, 32'hA5A5_0F0F);
        chk("idle_ack_cyc", {31'd0, bus_cyc_o}, 32'd0);

        // Back-to-back reads with ce held throughout.
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0200; cpu_sel_i = 4'hF;
        #1 chk("b2b_c0_stall", {31'd0, stall_req_o}, 32'd1);
        @(negedge clk);
        chk("b2b_c1_cyc", {31'd0, bus_cyc_o}, 32'd1);
        chk("b2b_c1_addr", bus_addr_o, 32'h0000_0200);
        bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
        @(negedge clk);
        chk("b2b_c2_cyc", {31'd0, bus_cyc_o}, 32'd0);
        chk("b2b_c2_stall", {31'd0, stall_req_o}, 32'd0);
        chk("b2b_c2_rdata", cpu_data_o, 32'h1111_1111);
        bus_ack_i = 1'b0; cpu_addr_i = 32'h0000_0300;
        @(negedge clk);
        chk("b2b_c3_cyc", {31'd0, bus_cyc_o}, 32'd0);
        chk("b2b_c3_stall", {31'd0, stall_req_o}, 32'd1);
        @(negedge clk);
        chk("b2b_c4_cyc", {31'd0, bus_cyc_o}, 32'd1);
        chk("b2b_c4_addr", bus_addr_o, 32'h0000_0300);
        bus_ack_i = 1'b1; bus_data_i = 32'h2222_2222;
        @(negedge clk);
        chk("b2b_c5_stall", {31'd0, stall_req_o}, 32'd0);
        chk("b2b_c5_rdata", cpu_data_o, 32'h2222_2222);
        bus_ack_i = 1'b0; cpu_ce_i = 1'b0;
        @(negedge clk);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // No ack: abort after TIMEOUT BUSY cycles, err in the release cycle.
        begin
            int n;
            bit seen;
            n = 0; seen = 1'b0;
            @(negedge clk);
            cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF;
            while (!seen && n < 40) begin
                @(negedge clk);
                n++;
                if (err_o) seen = 1'b1;
            end
            chk("to_seen", {31'd0, seen}, 32'd1);
            chk("to_cycle", 32'(n), 32'd17);
            chk("to_rdata", cpu_data_o, 32'd0);
            chk("to_stall", {31'd0, stall_req_o}, 32'd0);
            cpu_ce_i = 1'b0;
            @(negedge clk);
            chk("to_err_pulse", {31'd0, err_o}, 32'd0);
            chk("to_cyc", {31'd0, bus_cyc_o}, 32'd0);
        end
`else
        // No timeout: a 20-cycle wait still completes normally, err stays low.
        exp_q.push_back(32'hCAFE_F00D);
        xact(1'b0, 32'h0000_0040, 4'hF, 32'h0, 20, 32'hCAFE_F00D, 32'h0000_0040, st);
        chk("long_stall_cycles", 32'(st), 32'd22);
        chk("long_err", {31'd0, err_o}, 32'd0);
`endif

        // Reset in BUSY cycle 2, then a stray ack.
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0080; cpu_sel_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rb_c2_cyc", {31'd0, bus_cyc_o}, 32'd1);
        rst_n = 1'b1; cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("rb_cyc", {31'd0, bus_cyc_o}, 32'd0);
        chk("rb_stb", {31'd0, bus_stb_o}, 32'd0);
        chk("rb_addr", bus_addr_o, 32'd0);
        chk("rb_rdata", cpu_data_o, 32'd0);
        rst_n = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
        @(negedge clk);
        bus_ack_i = 1'b0;
        chk("rb_stray_rdata", cpu_data_o, 32'd0);
        chk("rb_stray_cyc", {31'd0, bus_cyc_o}, 32'd0);
        @(negedge clk);
        chk("rb_stray_stall", {31'd0, stall_req_o}, 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
